// File: rtl/serial_sub_pkg.sv
// Shared state encoding, default width and the full-subtractor equation
// used by the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;

  // Returns {bout, d} for one bit of a - b - bin.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
    logic d;
    logic bout;
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
    return {bout, d};
  endfunction

endpackage

// File: rtl/sub_1bit.sv
// 1-bit full subtractor: d = a - b - bin, bout = borrow out.
// Purely combinational, no state, no handshake.
module sub_1bit
  import serial_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign {bout, d} = full_sub(a, b, bin);

endmodule

// File: rtl/serial_sub_nbit.sv
// Bit-serial a - b, LSB first, one bit per clock through a single sub_1bit.
// Latency: out_valid visible WIDTH cycles after the input handshake.
// Backpressure: holds in DONE with diff/borrow stable until out_ready; in_ready only in IDLE.
module serial_sub_nbit
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             d_bit;
  logic             bout_bit;
  logic             last_bit;

  sub_1bit u_sub (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bin),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign last_bit  = (cnt == LAST);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // New difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  always_comb begin
    res_nxt            = res_sh >> 1;
    res_nxt[WIDTH-1]   = d_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // diff/borrow are separate from the working register so they only change
  // when a new result completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      bin    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh <= a;
            b_sh <= b;
            bin  <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nxt;
          bin    <= bout_bit;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            diff   <= res_nxt;
            borrow <= bout_bit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_nbit.sv
// Directed and randomised checks of serial_sub_nbit at WIDTH = 1, 4 and 8.
module tb_serial_sub_nbit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv1, ir1, ov1, or1, bo1;
  logic [0:0] a1, b1, d1;
  logic       iv4, ir4, ov4, or4, bo4;
  logic [3:0] a4, b4, d4;
  logic       iv8, ir8, ov8, or8, bo8;
  logic [7:0] a8, b8, d8;

  int errors = 0;
  int checks = 0;

  serial_sub_nbit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1), .diff(d1), .borrow(bo1)
  );
  serial_sub_nbit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .diff(d4), .borrow(bo4)
  );
  serial_sub_nbit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .borrow(bo8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int w, input logic [7:0] a, input logic [7:0] b, input logic v);
    case (w)
      1: begin a1 = a[0:0]; b1 = b[0:0]; iv1 = v; end
      4: begin a4 = a[3:0]; b4 = b[3:0]; iv4 = v; end
      default: begin a8 = a; b8 = b; iv8 = v; end
    endcase
  endtask

  task automatic set_or(input int w, input logic v);
    case (w)
      1: or1 = v;
      4: or4 = v;
      default: or8 = v;
    endcase
  endtask

  function automatic logic get_ir(input int w);
    case (w)
      1: return ir1;
      4: return ir4;
      default: return ir8;
    endcase
  endfunction

  function automatic logic get_ov(input int w);
    case (w)
      1: return ov1;
      4: return ov4;
      default: return ov8;
    endcase
  endfunction

  // {borrow, diff} with borrow at bit position w
  function automatic logic [8:0] get_res(input int w);
    case (w)
      1: return {7'b0, bo1, d1};
      4: return {4'b0, bo4, d4};
      default: return {bo8, d8};
    endcase
  endfunction

  function automatic logic [8:0] model(input int w, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] mask, am, bm, r;
    mask = (9'd1 << w) - 9'd1;
    am   = {1'b0, a} & mask;
    bm   = {1'b0, b} & mask;
    r    = (am - bm) & mask;
    if (am < bm) r = r | (9'd1 << w);
    return r;
  endfunction

  // Presents operands until accepted; returns just after the accepting edge.
  task automatic send(input int w, input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    set_in(w, a, b, 1'b1);
    while (!get_ir(w) && n < 50) begin tick(); n++; end
    chk("accept_wait", 32'(n < 50), 32'd1);
    tick();
    set_in(w, a, b, 1'b0);
  endtask

  // lat = number of edges after the accepting edge until out_valid is seen.
  task automatic wait_out(input int w, output int lat);
    lat = 0;
    while (!get_ov(w) && lat < 100) begin tick(); lat++; end
    chk("out_valid_wait", 32'(get_ov(w)), 32'd1);
  endtask

  task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b,
                       input logic [8:0] exp, input string tag);
    int lat;
    send(w, a, b);
    wait_out(w, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(w));
    chk({tag, "_res"}, 32'(get_res(w)), 32'(exp));
    chk({tag, "_ir_busy"}, 32'(get_ir(w)), 32'd0);
    set_or(w, 1'b1);
    tick();
    set_or(w, 1'b0);
    chk({tag, "_ov_drop"}, 32'(get_ov(w)), 32'd0);
    chk({tag, "_ir_idle"}, 32'(get_ir(w)), 32'd1);
    chk({tag, "_held"}, 32'(get_res(w)), 32'(exp));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cyc, last, n;
    logic [7:0] ra, rb;
    logic orv;
    logic [3:0] ta [3];
    logic [3:0] tb [3];
    logic [8:0] te [3];

    rst_n = 1'b0;
    set_in(1, 8'd0, 8'd0, 1'b0); set_in(4, 8'd0, 8'd0, 1'b0); set_in(8, 8'd0, 8'd0, 1'b0);
    or1 = 1'b0; or4 = 1'b0; or8 = 1'b0;
    tick(); tick();
    chk("rst_ir4", 32'(ir4), 32'd1);
    chk("rst_ov4", 32'(ov4), 32'd0);
    chk("rst_res4", 32'(get_res(4)), 32'd0);
    chk("rst_ir8", 32'(ir8), 32'd1);
    chk("rst_res8", 32'(get_res(8)), 32'd0);
    rst_n = 1'b1;
    tick();

    // basic and boundary vectors
    do_op(4, 8'd5, 8'd3, 9'h002, "w4_5m3");
    do_op(4, 8'd3, 8'd5, 9'h01E, "w4_3m5");
    do_op(4, 8'd0, 8'd1, 9'h01F, "w4_0m1");
    do_op(4, 8'hF, 8'hF, 9'h000, "w4_FmF");
    do_op(1, 8'd0, 8'd1, 9'h003, "w1_0m1");
    do_op(1, 8'd1, 8'd1, 9'h000, "w1_1m1");
    do_op(1, 8'd1, 8'd0, 9'h001, "w1_1m0");
    do_op(8, 8'd0, 8'd1, 9'h1FF, "w8_0m1");
    do_op(8, 8'h80, 8'h7F, 9'h001, "w8_80m7F");
    do_op(8, 8'h10, 8'h20, 9'h1F0, "w8_10m20");

    // backpressure with ignored in_valid pulses
    send(4, 8'd6, 8'd2);
    wait_out(4, lat);
    for (int i = 0; i < 10; i++) begin
      set_in(4, 8'd9, 8'd1, i[0]);
      tick();
      chk("bp_ov", 32'(ov4), 32'd1);
      chk("bp_res", 32'(get_res(4)), 32'h004);
      chk("bp_ir", 32'(ir4), 32'd0);
    end
    set_in(4, 8'd9, 8'd1, 1'b0);
    set_or(4, 1'b1);
    tick();
    set_or(4, 1'b0);
    chk("bp_ov_drop", 32'(ov4), 32'd0);
    tick();
    chk("bp_still_idle", 32'(ir4), 32'd1);
    do_op(4, 8'd12, 8'd4, 9'h008, "after_bp");

    // reset during RUN
    send(4, 8'd7, 8'd2);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("rrun_ov", 32'(ov4), 32'd0);
    chk("rrun_res", 32'(get_res(4)), 32'd0);
    chk("rrun_ir", 32'(ir4), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rrun_ov_after", 32'(ov4), 32'd0);
    do_op(4, 8'd7, 8'd2, 9'h005, "after_rrun");

    // reset during DONE
    send(8, 8'd3, 8'd9);
    wait_out(8, lat);
    chk("rdone_res_pre", 32'(get_res(8)), 32'h1FA);
    rst_n = 1'b0;
    #1;
    chk("rdone_ov", 32'(ov8), 32'd0);
    chk("rdone_res", 32'(get_res(8)), 32'd0);
    chk("rdone_ir", 32'(ir8), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // back-to-back with out_ready tied high
    ta[0] = 4'd9; tb[0] = 4'd4; te[0] = 9'h005;
    ta[1] = 4'd2; tb[1] = 4'd8; te[1] = 9'h01A;
    ta[2] = 4'd1; tb[2] = 4'd1; te[2] = 9'h000;
    set_or(4, 1'b1);
    set_in(4, {4'd0, ta[0]}, {4'd0, tb[0]}, 1'b1);
    cyc = 0;
    last = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!ov4 && n < 50) begin tick(); cyc++; n++; end
      chk("b2b_ov", 32'(ov4), 32'd1);
      chk("b2b_res", 32'(get_res(4)), 32'(te[k]));
      if (k > 0) chk("b2b_gap", 32'(cyc - last), 32'd6);
      last = cyc;
      if (k < 2) set_in(4, {4'd0, ta[k+1]}, {4'd0, tb[k+1]}, 1'b1);
      else set_in(4, 8'd0, 8'd0, 1'b0);
      tick();
      cyc++;
      chk("b2b_once", 32'(ov4), 32'd0);
    end
    set_or(4, 1'b0);
    tick();

    // random operands with random out_ready stalls
    for (int wi = 0; wi < 2; wi++) begin
      int w;
      w = (wi == 0) ? 4 : 8;
      for (int i = 0; i < 500; i++) begin
        ra  = 8'($urandom);
        rb  = 8'($urandom);
        orv = 1'($urandom_range(0, 1));
        set_or(w, orv);
        send(w, ra, rb);
        wait_out(w, lat);
        chk("rnd_lat", 32'(lat), 32'(w));
        if (!orv) begin
          repeat ($urandom_range(0, 3)) tick();
          chk("rnd_stall_ov", 32'(get_ov(w)), 32'd1);
          set_or(w, 1'b1);
        end
        chk("rnd_res", 32'(get_res(w)), 32'(model(w, ra, rb)));
        tick();
        set_or(w, 1'b0);
        chk("rnd_ov_drop", 32'(get_ov(w)), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
